dmem_arbiter: RTL and testbench

//  Sequences and shares the single-port data memory between two requesters:

---
 rtl/dmem_arbiter_if.sv | 22 ++
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports C/A plus the single-port data memory bus
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
  logic c_req, c_we, c_gnt, c_done, c_err, cpu_stall;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic a_req, a_we, a_gnt, a_done, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, a_req, a_we, a_addr, a_wdata, mem_rdata,
    output c_gnt, c_done, c_rdata, c_err, cpu_stall, a_gnt, a_done, a_rdata, a_err,
           mem_we, mem_re, mem_addr, mem_wdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, a_req, a_we, a_addr, a_wdata, mem_rdata,
    input  c_gnt, c_done, c_rdata, c_err, cpu_stall, a_gnt, a_done, a_rdata, a_err,
           mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between CPU port C and aux port A.
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority with starvation escape.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 512,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic owner, lat_we, lat_err, a_win, any_req, take, sel_we, sel_oor;
  logic [ADDR_W-1:0] lat_addr, sel_addr;
  logic [31:0] lat_wdata, sel_wdata, c_rdata_q, a_rdata_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  assign any_req = bus.c_req | bus.a_req;
  assign take = state == IDLE && any_req;
`ifdef DMEM_ARB_RR_EN
  logic prio_a;
  assign a_win = bus.a_req & (~bus.c_req | prio_a);
  assign starve = '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) prio_a <= 1'b0;
    else if (take) prio_a <= ~a_win;
`else
  assign a_win = bus.a_req & (~bus.c_req | starve == SW'(MAX_WAIT));
  // A can only lose while below MAX_WAIT, so the increment saturates by construction
  always_ff @(posedge clk or posedge rst)
    if (rst) starve <= '0;
    else if (take && bus.a_req) starve <= a_win ? '0 : starve + 1'b1;
`endif
  assign sel_we = a_win ? bus.a_we : bus.c_we;
  assign sel_addr = a_win ? bus.a_addr : bus.c_addr;
  assign sel_wdata = a_win ? bus.a_wdata : bus.c_wdata;
  assign sel_oor = sel_addr >= ADDR_W'(DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    bus.c_gnt = 1'b0;
    bus.a_gnt = 1'b0;
    bus.c_done = 1'b0;
    bus.a_done = 1'b0;
    bus.c_err = 1'b0;
    bus.a_err = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_re = 1'b0;
    if (take) begin
      state_nx = sel_oor ? DONE : ACCESS;
      bus.c_gnt = ~rst & ~a_win;
      bus.a_gnt = ~rst & a_win;
    end
    if (state == ACCESS) begin
      state_nx = cnt == '0 ? DONE : ACCESS;
      bus.mem_we = lat_we;
      bus.mem_re = ~lat_we;
    end
    if (state == DONE) begin
      state_nx = IDLE;
      bus.c_done = ~owner;
      bus.a_done = owner;
      bus.c_err = ~owner & lat_err;
      bus.a_err = owner & lat_err;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner <= 1'b0;
      lat_we <= 1'b0;
      lat_err <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      cnt <= '0;
      c_rdata_q <= '0;
      a_rdata_q <= '0;
    end else begin
      if (take) begin
        owner <= a_win;
        lat_we <= sel_we;
        lat_err <= sel_oor;
        lat_addr <= sel_addr;
        lat_wdata <= sel_wdata;
        cnt <= CW'(MEM_LAT - 1);
        if (sel_oor && a_win) a_rdata_q <= '0;
        if (sel_oor && !a_win) c_rdata_q <= '0;
      end
      if (state == ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (state == ACCESS && cnt == '0 && !lat_we && owner) a_rdata_q <= bus.mem_rdata;
      if (state == ACCESS && cnt == '0 && !lat_we && !owner) c_rdata_q <= bus.mem_rdata;
    end
  assign bus.mem_addr = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.c_rdata = c_rdata_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.cpu_stall = bus.c_req & ~bus.c_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed traffic on both ports against a transaction-level model
module tb_dmem_arbiter;
  localparam int LAT = 3, DEPTH = 512, MW = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int next_free = 0, grant_cyc = -100, done_cyc = -100, losses = 0;
  logic own = 1'b0, acc_we = 1'b0, acc_oor = 1'b0, rr_a = 1'b0;
  logic [31:0] acc_addr = '0, acc_wdata = '0, exp_cr = '0, exp_ar = '0;
  logic g_c, g_a, c_ack = 1'b0, a_ack = 1'b0;
  dmem_arbiter_if #(.ADDR_W(32)) bus ();
  dmem_arbiter #(.ADDR_W(32), .DEPTH(DEPTH), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = bus.mem_addr < DEPTH ? mem[bus.mem_addr[8:0]] : 32'h0;
  always @(posedge clk) if (bus.mem_we && bus.mem_addr < DEPTH) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic issue(input bit a, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    if (a) begin bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; end
    else begin bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd; end
  endtask

  task automatic model_reset();
    next_free = 0; grant_cyc = -100; done_cyc = -100; losses = 0;
    own = 1'b0; acc_oor = 1'b0; rr_a = 1'b0; exp_cr = '0; exp_ar = '0; c_ack = 1'b0; a_ack = 1'b0;
  endtask

  // one clock: check the cycle at the falling edge, then retire acknowledged requests
  task automatic step();
    logic aw, granted, in_acc, is_done;
    logic [8:0] ectl, octl;
    @(negedge clk);
    cyc++;
    aw = 1'b0;
    granted = 1'b0;
    if (cyc >= next_free && (bus.c_req || bus.a_req)) begin
      granted = 1'b1;
      aw = bus.a_req && (!bus.c_req || (RR ? rr_a : losses == MW));
      if (bus.a_req) losses = aw ? 0 : losses + 1;
      rr_a = !aw;
      own = aw;
      acc_we = aw ? bus.a_we : bus.c_we;
      acc_addr = aw ? bus.a_addr : bus.c_addr;
      acc_wdata = aw ? bus.a_wdata : bus.c_wdata;
      acc_oor = acc_addr >= DEPTH;
      grant_cyc = cyc;
      done_cyc = cyc + (acc_oor ? 1 : LAT + 1);
      next_free = done_cyc + 1;
    end
    in_acc = !acc_oor && cyc > grant_cyc && cyc < done_cyc;
    is_done = cyc == done_cyc;
    if (is_done) begin
      if (acc_oor) begin if (own) exp_ar = '0; else exp_cr = '0; end
      else if (acc_we) ref_mem[acc_addr[8:0]] = acc_wdata;
      else if (own) exp_ar = ref_mem[acc_addr[8:0]];
      else exp_cr = ref_mem[acc_addr[8:0]];
    end
    ectl = {granted & !aw, granted & aw, is_done & !own, is_done & own, is_done & !own & acc_oor,
            is_done & own & acc_oor, in_acc & acc_we, in_acc & !acc_we, bus.c_req & !(is_done & !own)};
    octl = {bus.c_gnt, bus.a_gnt, bus.c_done, bus.a_done, bus.c_err, bus.a_err, bus.mem_we, bus.mem_re, bus.cpu_stall};
    chk("ctl", {23'b0, octl}, {23'b0, ectl});
    if (in_acc) chk("mem_addr", bus.mem_addr, acc_addr);
    if (in_acc && acc_we) chk("mem_wdata", bus.mem_wdata, acc_wdata);
    if (is_done) begin
      chk("c_rdata", bus.c_rdata, exp_cr);
      chk("a_rdata", bus.a_rdata, exp_ar);
    end
    g_c = bus.c_gnt;
    g_a = bus.a_gnt;
    c_ack = bus.c_done;
    a_ack = bus.a_done;
    @(posedge clk);
    #1;
    if (c_ack) bus.c_req = 1'b0;
    if (a_ack) bus.a_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (bus.c_req || bus.a_req); i++) step();
    chk("drain", {30'b0, bus.c_req, bus.a_req}, 32'h0);
  endtask

  initial begin
    logic e;
    logic prev;
    int n;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    #12;
    chk("rst_ctl", {23'b0, bus.c_gnt, bus.a_gnt, bus.c_done, bus.a_done, bus.c_err, bus.a_err,
                    bus.mem_we, bus.mem_re, bus.cpu_stall}, 32'h0);
    chk("rst_crd", bus.c_rdata, 32'h0);
    chk("rst_ard", bus.a_rdata, 32'h0);
    chk("rst_maddr", bus.mem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    // write then read back on C
    issue(0, 1, 5, 32'h1234);
    drain();
    issue(0, 0, 5, 0);
    drain();
    chk("t1_rd", bus.c_rdata, 32'h1234);
    // simultaneous requests
    issue(0, 0, 3, 0);
    issue(1, 0, 4, 0);
    step();
    chk("t2_first", {30'b0, g_c, g_a}, RR ? 32'h1 : 32'h2);
    drain();
    // both ports requesting back to back
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      if (!bus.c_req) issue(0, 0, $urandom % 16, 0);
      if (!bus.a_req) issue(1, 0, $urandom % 16, 0);
      e = RR ? (n == 0 ? rr_a : !prev) : (n % 5 == 4);
      step();
      if (g_c || g_a) begin
        chk("t3_seq", {31'b0, g_a}, {31'b0, e});
        prev = g_a;
        n++;
      end
    end
    chk("t3_count", n, 10);
    drain();
    // out-of-range read on A
    issue(1, 0, 512, 0);
    drain();
    chk("t4_rdata", bus.a_rdata, 32'h0);
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if (!bus.c_req && $urandom % 3 == 0)
        issue(0, $urandom % 2, $urandom % 8 == 0 ? 510 + $urandom % 4 : $urandom % 16, $urandom);
      if (!bus.a_req && $urandom % 4 == 0)
        issue(1, $urandom % 2, $urandom % 8 == 0 ? 510 + $urandom % 4 : $urandom % 16, $urandom);
      step();
    end
    drain();
    // async reset in the first ACCESS cycle of a write aborts it
    issue(0, 1, 7, 32'hdeadbeef);
    step();
    #2 rst = 1'b1;
    #1;
    chk("t5_abort", {26'b0, bus.mem_we, bus.mem_re, bus.c_gnt, bus.a_gnt, bus.c_done, bus.a_done}, 32'h0);
    bus.c_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    chk("t5_crd", bus.c_rdata, 32'h0);
    chk("t5_ard", bus.a_rdata, 32'h0);
    issue(0, 0, 7, 0);
    drain();
    chk("t5_rd", bus.c_rdata, ref_mem[7]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
